// File: rtl/starfield_pkg.sv
// Shared timing constants, LFSR definition and colour types for the starfield pixel generator.
package starfield_pkg;

  localparam int CNT_W = 10;
  localparam int CH_W  = 2;
  localparam int RGB_W = 3 * CH_W;

  localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
  localparam logic [CNT_W-1:0] H_TOTAL  = 10'd800;
  localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
  localparam logic [CNT_W-1:0] V_TOTAL  = 10'd525;
  localparam logic [CNT_W-1:0] V_LAST   = V_TOTAL - 10'd1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_BASE = 16'hACE1;
  localparam logic [7:0]  DENSITY   = 8'd4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Seed for a displayed line; the scroll offset shifts which virtual line is shown.
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] line_seed(input logic [CNT_W-1:0] v,
                                            input logic [CNT_W-1:0] scroll);
    logic [CNT_W-1:0] vs;
    logic [15:0]      s;
    vs = v - scroll;
    s  = SEED_BASE ^ {vs[5:0], vs};
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

endpackage

// File: rtl/sf_lfsr16.sv
// 16-bit Galois LFSR with synchronous load, step and hold; resets to the seed base.
import starfield_pkg::*;

module sf_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] load_val,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_BASE;
    end else if (load) begin
      lfsr <= load_val;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/starfield_gen.sv
// Vertically scrolling starfield pixel generator; registered RGB with syncs delayed to match.
import starfield_pkg::*;

module starfield_gen (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] h_count,
  input  logic [CNT_W-1:0] v_count,
  input  logic             bright,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [1:0]       speed,
  input  logic             freeze,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync_out,
  output logic             vsync_out
);

  logic [CNT_W-1:0] scroll;
  logic [CNT_W-1:0] v_next;
  logic [15:0]      lfsr;
  logic [15:0]      seed;
  logic             in_active;
  logic             at_reload;
  logic             frame_tick;
  logic             star;
  logic [CH_W-1:0]  lvl;
  logic [CH_W-1:0]  lvl_half;
  rgb_t             color;

  assign in_active  = (h_count < H_ACTIVE);
  assign at_reload  = (h_count == H_ACTIVE);
  assign v_next     = (v_count == V_LAST) ? '0 : v_count + 10'd1;
  assign seed       = line_seed(v_next, scroll);
  assign frame_tick = (v_count == V_ACTIVE) && (h_count == '0);

  // Reload at the first blanking pixel so the next line starts from its own seed.
  sf_lfsr16 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (at_reload),
    .step     (in_active),
    .load_val (seed),
    .lfsr     (lfsr)
  );

  // Scroll only moves in vertical blanking, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll <= '0;
    end else if (frame_tick && !freeze) begin
      scroll <= scroll + {8'b0, speed};
    end
  end

  assign star     = (lfsr[15:8] < DENSITY);
  assign lvl      = lfsr[1:0] | 2'b01;
  assign lvl_half = lvl >> 1;

  always_comb begin
    color = '0;
    if (lfsr[2]) begin
      color.r = lvl_half;
      color.g = lvl_half;
      color.b = lvl;
    end else begin
      color.r = lvl;
      color.g = lvl;
      color.b = lvl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb       <= (bright && star) ? color : '0;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule
